// File: rtl/capture_seq_ctrl_if.sv
// Capture sequencer signal bundle: ADC/trigger/host inputs and frame-RAM write port.
// The sequencer uses the slave modport; the driving environment uses the master modport.
interface capture_seq_ctrl_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 10
);
  logic signed [WIDTH-1:0]  adc_in;
  logic                     adc_valid;
  logic                     trig_in;
  logic                     arm;
  logic                     abort;
  logic        [ADDR_W-1:0] cap_len;
  logic                     done_ack;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [WIDTH-1:0]  wr_data;
  logic                     busy;
  logic                     done;
  logic                     auto_trig;

  modport master (
    output adc_in, adc_valid, trig_in, arm, abort, cap_len, done_ack,
    input  wr_en, wr_addr, wr_data, busy, done, auto_trig
  );

  modport slave (
    input  adc_in, adc_valid, trig_in, arm, abort, cap_len, done_ack,
    output wr_en, wr_addr, wr_data, busy, done, auto_trig
  );
endinterface

// File: rtl/capture_seq_ctrl.sv
// One-shot ADC frame capture sequencer: arm, holdoff, trigger edge, write cap_len+1 samples.
// Define CAPTURE_AUTO_TRIG_EN to force a trigger after TIMEOUT cycles in WAIT_TRIG.
module capture_seq_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned HOLDOFF = 6,
  parameter int unsigned TIMEOUT = 100000
) (
  input logic               clk,
  input logic               rst_n,
  capture_seq_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StArm, StWaitTrig, StCapture, StDone} state_e;

  state_e                     state_q;
  logic                       trig_d;
  logic        [HoldW-1:0]    hold_cnt;
  logic        [ADDR_W-1:0]   cap_len_q;
  logic        [ADDR_W-1:0]   wr_cnt;
  logic                       wr_en_q;
  logic        [ADDR_W-1:0]   wr_addr_q;
  logic signed [WIDTH-1:0]    wr_data_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       trig_edge;

  assign trig_edge = bus.trig_in & ~trig_d;

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int unsigned TimeW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TimeW-1:0] to_cnt;
  logic             auto_trig_q;
  assign bus.auto_trig = auto_trig_q;
`else
  assign bus.auto_trig = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      trig_d      <= 1'b0;
      hold_cnt    <= '0;
      cap_len_q   <= '0;
      wr_cnt      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      to_cnt      <= '0;
      auto_trig_q <= 1'b0;
`endif
    end else begin
      trig_d  <= bus.trig_in;
      wr_en_q <= 1'b0;
      if (bus.abort) begin
        // Abort wins over everything, including a simultaneous arm in IDLE.
        state_q <= StIdle;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.arm) begin
              cap_len_q   <= bus.cap_len;
              hold_cnt    <= '0;
              busy_q      <= 1'b1;
              state_q     <= StArm;
`ifdef CAPTURE_AUTO_TRIG_EN
              auto_trig_q <= 1'b0;
`endif
            end
          end
          StArm: begin
            if (hold_cnt == HoldW'(HOLDOFF)) begin
              state_q <= StWaitTrig;
`ifdef CAPTURE_AUTO_TRIG_EN
              to_cnt  <= '0;
`endif
            end else if (bus.adc_valid) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          StWaitTrig: begin
            if (trig_edge) begin
              state_q <= StCapture;
              wr_cnt  <= '0;
`ifdef CAPTURE_AUTO_TRIG_EN
            end else if (to_cnt == TimeW'(TIMEOUT - 1)) begin
              state_q     <= StCapture;
              wr_cnt      <= '0;
              auto_trig_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
`endif
            end
          end
          StCapture: begin
            if (bus.adc_valid) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_cnt;
              wr_data_q <= bus.adc_in;
              wr_cnt    <= wr_cnt + 1'b1;
              if (wr_cnt == cap_len_q) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          StDone: begin
            if (bus.done_ack) begin
              state_q <= StIdle;
              done_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Directed self-checking bench for capture_seq_ctrl (HOLDOFF=6, TIMEOUT=50).
// The timeout scenario follows whichever build of CAPTURE_AUTO_TRIG_EN is compiled.
module tb_capture_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  capture_seq_ctrl_if #(.WIDTH(16), .ADDR_W(10)) bus ();

  capture_seq_ctrl #(
    .WIDTH  (16),
    .ADDR_W (10),
    .HOLDOFF(6),
    .TIMEOUT(50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm at edge E0 with adc_in=0; cap_len is scrambled afterwards to prove it was latched.
  task automatic arm_pulse(input logic [9:0] len);
    bus.cap_len   = len;
    bus.arm       = 1'b1;
    bus.adc_valid = 1'b1;
    bus.adc_in    = 16'sd0;
    bus.trig_in   = 1'b0;
    tick();
    bus.arm     = 1'b0;
    bus.cap_len = ~len;
  endtask

  task automatic test_reset();
    bus.adc_in = '0; bus.adc_valid = 0; bus.trig_in = 0; bus.arm = 0;
    bus.abort = 0; bus.cap_len = '0; bus.done_ack = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 16'sd0) begin errors++; $display("FAIL reset_wr_data got %0d want 0", bus.wr_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.auto_trig !== 1'b0) begin errors++; $display("FAIL reset_auto_trig got %b want 0", bus.auto_trig); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // ARM exits at E7, trigger sampled at E11, samples 12..19 written at E12..E19.
  task automatic test_basic();
    logic exp_en;
    arm_pulse(10'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_arm got %b want 1", bus.busy); end
    for (int k = 1; k <= 22; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 11);
      tick();
      exp_en = (k >= 12 && k <= 19);
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("FAIL basic_wr_en k=%0d got %b want %b", k, bus.wr_en, exp_en); end
      if (exp_en) begin
        checks++; if (bus.wr_addr !== 10'(k - 12)) begin errors++; $display("FAIL basic_wr_addr k=%0d got %0d want %0d", k, bus.wr_addr, k - 12); end
        checks++; if (bus.wr_data !== 16'(k)) begin errors++; $display("FAIL basic_wr_data k=%0d got %0d want %0d", k, bus.wr_data, k); end
      end
      checks++; if (bus.done !== (k >= 19)) begin errors++; $display("FAIL basic_done k=%0d got %b want %b", k, bus.done, k >= 19); end
      checks++; if (bus.busy !== (k < 19)) begin errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, bus.busy, k < 19); end
    end
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_ack got %b want 0", bus.done); end
  endtask

  // Rise at E3 falls inside holdoff and is still high at WAIT_TRIG entry; only the E20 rise counts.
  task automatic test_holdoff();
    logic exp_en;
    arm_pulse(10'd1);
    for (int k = 1; k <= 24; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 3 && k <= 9) || (k >= 20);
      tick();
      exp_en = (k == 21 || k == 22);
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("FAIL holdoff_wr_en k=%0d got %b want %b", k, bus.wr_en, exp_en); end
      if (exp_en) begin
        checks++; if (bus.wr_addr !== 10'(k - 21)) begin errors++; $display("FAIL holdoff_wr_addr k=%0d got %0d want %0d", k, bus.wr_addr, k - 21); end
      end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL holdoff_done got %b want 1", bus.done); end
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
  endtask

  task automatic test_gapped();
    logic exp_en;
    arm_pulse(10'd3);
    for (int k = 1; k <= 21; k++) begin
      bus.adc_in    = 16'(k);
      bus.trig_in   = (k >= 11);
      bus.adc_valid = (k < 12) || (k % 2 == 0);
      tick();
      exp_en = (k >= 12 && k <= 18 && (k % 2 == 0));
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("FAIL gapped_wr_en k=%0d got %b want %b", k, bus.wr_en, exp_en); end
      if (exp_en) begin
        checks++; if (bus.wr_addr !== 10'((k - 12) / 2)) begin errors++; $display("FAIL gapped_wr_addr k=%0d got %0d want %0d", k, bus.wr_addr, (k - 12) / 2); end
        checks++; if (bus.wr_data !== 16'(k)) begin errors++; $display("FAIL gapped_wr_data k=%0d got %0d want %0d", k, bus.wr_data, k); end
      end
      checks++; if (bus.done !== (k >= 18)) begin errors++; $display("FAIL gapped_done k=%0d got %b want %b", k, bus.done, k >= 18); end
    end
    bus.adc_valid = 1'b1;
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
  endtask

  task automatic test_abort();
    logic exp_en;
    arm_pulse(10'd15);
    for (int k = 1; k <= 13; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 11);
      tick();
    end
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'd1) begin errors++; $display("FAIL abort_second_write got en=%b addr=%0d want en=1 addr=1", bus.wr_en, bus.wr_addr); end
    bus.abort  = 1'b1;
    bus.adc_in = 16'sd14;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b want 0", bus.wr_en); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.done); end
    arm_pulse(10'd1);
    for (int k = 1; k <= 14; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 11);
      tick();
      exp_en = (k == 12 || k == 13);
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("FAIL rearm_wr_en k=%0d got %b want %b", k, bus.wr_en, exp_en); end
      if (exp_en) begin
        checks++; if (bus.wr_addr !== 10'(k - 12)) begin errors++; $display("FAIL rearm_wr_addr k=%0d got %0d want %0d", k, bus.wr_addr, k - 12); end
      end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rearm_done got %b want 1", bus.done); end
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
  endtask

  task automatic test_handshake();
    arm_pulse(10'd0);
    for (int k = 1; k <= 12; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 11);
      tick();
    end
    checks++; if (bus.done !== 1'b1 || bus.wr_data !== 16'sd12) begin errors++; $display("FAIL hs_single_write got done=%b data=%0d want done=1 data=12", bus.done, bus.wr_data); end
    bus.arm = 1'b1; tick(); bus.arm = 1'b0; tick();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL hs_arm_in_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hs_done_ack got %b want 0", bus.done); end
    bus.arm = 1'b1; bus.abort = 1'b1; tick();
    bus.arm = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hs_arm_abort got busy=%b want 0", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hs_arm_abort_late got busy=%b want 0", bus.busy); end
    // abort also leaves DONE
    arm_pulse(10'd0);
    for (int k = 1; k <= 12; k++) begin
      bus.trig_in = (k >= 11);
      tick();
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hs_abort_in_done got done=%b want 0", bus.done); end
  endtask

  task automatic test_timeout();
    logic exp_en;
`ifdef CAPTURE_AUTO_TRIG_EN
    // WAIT_TRIG entered at E7; forced trigger at E57; writes at E58, E59.
    arm_pulse(10'd1);
    for (int k = 1; k <= 61; k++) begin
      bus.adc_in = 16'(k);
      tick();
      exp_en = (k == 58 || k == 59);
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("FAIL timeout_wr_en k=%0d got %b want %b", k, bus.wr_en, exp_en); end
      checks++; if (bus.auto_trig !== (k >= 57)) begin errors++; $display("FAIL timeout_auto_trig k=%0d got %b want %b", k, bus.auto_trig, k >= 57); end
    end
    checks++; if (bus.wr_data !== 16'sd59 || bus.done !== 1'b1) begin errors++; $display("FAIL timeout_last got data=%0d done=%b want data=59 done=1", bus.wr_data, bus.done); end
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
    checks++; if (bus.auto_trig !== 1'b1) begin errors++; $display("FAIL timeout_hold got %b want 1", bus.auto_trig); end
    arm_pulse(10'd1);
    checks++; if (bus.auto_trig !== 1'b0) begin errors++; $display("FAIL timeout_rearm_clear got %b want 0", bus.auto_trig); end
`else
    arm_pulse(10'd1);
    for (int k = 1; k <= 210; k++) begin
      bus.adc_in = 16'(k);
      tick();
      exp_en = 1'b0;
      checks++; if (bus.wr_en !== exp_en || bus.auto_trig !== 1'b0) begin errors++; $display("FAIL notimeout k=%0d got en=%b auto=%b want 0 0", k, bus.wr_en, bus.auto_trig); end
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL notimeout_busy got %b want 1", bus.busy); end
`endif
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic test_async_reset();
    arm_pulse(10'd15);
    for (int k = 1; k <= 13; k++) begin
      bus.adc_in  = 16'(k);
      bus.trig_in = (k >= 11);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_now got en=%b busy=%b want 0 0", bus.wr_en, bus.busy); end
    checks++; if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL areset_addr got %0d want 0", bus.wr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_after k=%0d got en=%b busy=%b want 0 0", k, bus.wr_en, bus.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_holdoff();
    test_gapped();
    test_abort();
    test_handshake();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
